// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM compare stage and its bench.
// Holds the run/off state encoding and the duty saturation rule.
package pwm_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_PERIODS_W = 4;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } pwm_state_e;

    // Duties above a full period (2**width high cycles) clamp to a full period.
    function automatic int unsigned sat_duty(input int unsigned data, input int unsigned width);
        int unsigned max_duty;
        max_duty = 32'd1 << width;
        return (data > max_duty) ? max_duty : data;
    endfunction

endpackage

// File: rtl/duty_shadow.sv
// Duty shadow register: accepts one duty write via valid/ready and
// hands it to the active duty only on a period boundary.
module duty_shadow
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             wrap,
    input  logic             duty_valid,
    input  logic [WIDTH:0]   duty_data,
    output logic             duty_ready,
    output logic [WIDTH:0]   active_duty
);

    localparam int unsigned DW = WIDTH + 1;

    logic [WIDTH:0] shadow;
    logic           pending;
    logic           accept;
    logic [WIDTH:0] duty_sat;

    assign duty_ready = !pending;
    assign accept     = duty_valid && !pending;
    assign duty_sat   = DW'(sat_duty(32'(duty_data), WIDTH));

    // Accept and apply are exclusive: accept needs pending=0, apply needs pending=1,
    // so a write landing on a wrap edge waits for the following wrap.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            shadow      <= '0;
            pending     <= 1'b0;
            active_duty <= '0;
        end else if (wrap && pending) begin
            active_duty <= shadow;
            pending     <= 1'b0;
        end else if (accept) begin
            shadow  <= duty_sat;
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_compare.sv
// PWM compare stage: turns the free-running count into a registered PWM
// output and a periodic interrupt, with duty changes only at period boundaries.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned PERIODS_W = DEFAULT_PERIODS_W
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic [WIDTH-1:0]     count,
    input  logic                 wrap,
    input  logic                 enable,
    input  logic                 duty_valid,
    input  logic [WIDTH:0]       duty_data,
    output logic                 duty_ready,
    input  logic [PERIODS_W-1:0] irq_periods,
    output logic [WIDTH:0]       active_duty,
    output logic                 pwm_out,
    output logic                 period_irq
);

    pwm_state_e           state;
    pwm_state_e           state_next;
    logic [WIDTH:0]       count_ext;
    logic                 pwm_next;
    logic [PERIODS_W-1:0] period_cnt;
    logic [PERIODS_W-1:0] period_cnt_next;
    logic                 irq_next;

    duty_shadow #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .wrap       (wrap),
        .duty_valid (duty_valid),
        .duty_data  (duty_data),
        .duty_ready (duty_ready),
        .active_duty(active_duty)
    );

    always_comb begin
        state_next = state;
        if (wrap) begin
            state_next = enable ? RUN : OFF;
        end
    end

    assign count_ext = {1'b0, count};
    assign pwm_next  = (state_next == RUN) && (count_ext < active_duty);

    // A match on a RUN wrap still pulses even if that wrap also drops to OFF:
    // the period it closes was completed.
    always_comb begin
        period_cnt_next = period_cnt;
        irq_next        = 1'b0;
        if (irq_periods == '0) begin
            period_cnt_next = '0;
        end else if (wrap && (state == RUN)) begin
            if (period_cnt == irq_periods - PERIODS_W'(1)) begin
                period_cnt_next = '0;
                irq_next        = 1'b1;
            end else if (period_cnt >= irq_periods) begin
                period_cnt_next = '0;
            end else begin
                period_cnt_next = period_cnt + PERIODS_W'(1);
            end
        end
        if (state_next == OFF) begin
            period_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state      <= OFF;
            pwm_out    <= 1'b0;
            period_irq <= 1'b0;
            period_cnt <= '0;
        end else begin
            state      <= state_next;
            pwm_out    <= pwm_next;
            period_irq <= irq_next;
            period_cnt <= period_cnt_next;
        end
    end

endmodule
